// File: rtl/pc_stack16.sv
// Program counter with hold/increment/jump and a small hardware return-address stack.
// One action per enabled cycle, priority ret > call > load > inc; stack faults set a sticky error flag.
module pc_stack16 #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     inc,
   input  logic                     load,
   input  logic                     call,
   input  logic                     ret,
   input  logic [WIDTH-1:0]         load_addr,
   output logic [WIDTH-1:0]         pc,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     stack_empty,
   output logic                     stack_full,
   output logic                     stack_err
);

   localparam int unsigned     AW       = $clog2(DEPTH);
   localparam int unsigned     DW       = AW + 1;
   localparam logic [DW-1:0]   FULL_CNT = DW'(DEPTH);

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_INC,
      ACT_LOAD,
      ACT_PUSH,
      ACT_POP,
      ACT_FAULT
   } act_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] stack_mem [DEPTH];

   act_e             act;
   logic             is_empty, is_full;
   logic [WIDTH-1:0] pc_plus1;
   logic [AW-1:0]    push_idx, top_idx;
   logic             push_we;

   // Flags decode straight from the depth register, so they never glitch on input changes.
   assign is_empty = (depth_q == '0);
   assign is_full  = (depth_q == FULL_CNT);
   assign pc_plus1 = pc_q + WIDTH'(1);

   // Push writes slot depth; top lives at depth-1. Only the low bits are needed because a
   // push never happens when full and a pop never happens when empty.
   assign push_idx = depth_q[AW-1:0];
   assign top_idx  = depth_q[AW-1:0] - AW'(1);

   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      act = ACT_HOLD;
      if (ret)       act = is_empty ? ACT_FAULT : ACT_POP;
      else if (call) act = is_full  ? ACT_FAULT : ACT_PUSH;
      else if (load) act = ACT_LOAD;
      else if (inc)  act = ACT_INC;
   end

   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      err_d   = err_q;
      unique case (act)
         ACT_INC:   pc_d = pc_plus1;
         ACT_LOAD:  pc_d = load_addr;
         ACT_PUSH: begin
            pc_d    = load_addr;
            depth_d = depth_q + DW'(1);
         end
         ACT_POP: begin
            pc_d    = stack_mem[top_idx];
            depth_d = depth_q - DW'(1);
         end
         ACT_FAULT: err_d = 1'b1;
         default:   ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_VEC;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else if (en) begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   assign push_we = rst_n && en && (act == ACT_PUSH);

   // NOTE: the stack array has no reset; depth alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (push_we) stack_mem[push_idx] <= pc_plus1;
   end

   assign pc          = pc_q;
   assign depth       = depth_q;
   assign stack_empty = is_empty;
   assign stack_full  = is_full;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack16.sv
// Bench for pc_stack16: directed vector table, a hand-written stall sequence, then
// random stimulus checked against a queue-based reference model.
module tb_pc_stack16;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n, en, inc, load, call, ret;
   logic [15:0] load_addr;
   logic [15:0] pc;
   logic [2:0]  depth;
   logic        stack_empty, stack_full, stack_err;

   int checks   = 0;
   int failures = 0;

   pc_stack16 #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .inc(inc), .load(load), .call(call), .ret(ret),
      .load_addr(load_addr), .pc(pc), .depth(depth), .stack_empty(stack_empty),
      .stack_full(stack_full), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst_n, en, inc, load, call, ret;
      logic [15:0] addr;
      logic [15:0] exp_pc;
      int          exp_depth;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic add(input string name, input logic r, input logic e, input logic i,
                      input logic l, input logic c, input logic rt, input logic [15:0] a,
                      input logic [15:0] p, input int d, input logic er);
      vec_t v;
      v.name = name; v.rst_n = r; v.en = e; v.inc = i; v.load = l; v.call = c; v.ret = rt;
      v.addr = a; v.exp_pc = p; v.exp_depth = d; v.exp_err = er;
      vecs.push_back(v);
   endtask

   // Drive at the falling edge, let one rising edge happen, sample 1 time unit later.
   task automatic step(input logic r, input logic e, input logic i, input logic l,
                       input logic c, input logic rt, input logic [15:0] a);
      @(negedge clk);
      rst_n = r; en = e; inc = i; load = l; call = c; ret = rt; load_addr = a;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name, input logic [15:0] p, input int d,
                              input logic er);
      check({name, ".pc"},    int'(pc),          int'(p));
      check({name, ".depth"}, int'(depth),       d);
      check({name, ".err"},   int'(stack_err),   int'(er));
      check({name, ".empty"}, int'(stack_empty), int'(d == 0));
      check({name, ".full"},  int'(stack_full),  int'(d == DEPTH));
   endtask

   // Reference model: stack as a queue, pc as plain modular arithmetic.
   int          m_pc;
   int          m_stk[$];
   logic        m_err;

   task automatic model_step(input logic r, input logic e, input logic i, input logic l,
                             input logic c, input logic rt, input int a);
      if (!r) begin
         m_pc = 0; m_stk.delete(); m_err = 1'b0;
      end else if (e) begin
         if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1'b1;
         end else if (c) begin
            if (m_stk.size() < DEPTH) begin
               m_stk.push_back((m_pc + 1) % 65536);
               m_pc = a;
            end else m_err = 1'b1;
         end else if (l) m_pc = a;
         else if (i)     m_pc = (m_pc + 1) % 65536;
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
      load_addr = 16'h0000;

      //   name        rst en inc ld cl rt addr      pc        d  err
      add("rst0",      0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add("rst1",      0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add("inc1",      1, 1, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0);
      add("inc2",      1, 1, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 0);
      add("inc3",      1, 1, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 0);
      add("ld_fffe",   1, 1, 0, 1, 0, 0, 16'hFFFE, 16'hFFFE, 0, 0);
      add("inc_ffff",  1, 1, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0);
      add("inc_wrap",  1, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add("ld_0010",   1, 1, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0);
      add("call100",   1, 1, 0, 0, 1, 0, 16'h0100, 16'h0100, 1, 0);
      add("call200",   1, 1, 0, 0, 1, 0, 16'h0200, 16'h0200, 2, 0);
      add("ret0101",   1, 1, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0);
      add("ret0011",   1, 1, 0, 0, 0, 1, 16'h0000, 16'h0011, 0, 0);
      add("ld_0000",   1, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add("c10",       1, 1, 0, 0, 1, 0, 16'h0010, 16'h0010, 1, 0);
      add("c20",       1, 1, 0, 0, 1, 0, 16'h0020, 16'h0020, 2, 0);
      add("c30",       1, 1, 0, 0, 1, 0, 16'h0030, 16'h0030, 3, 0);
      add("c40",       1, 1, 0, 0, 1, 0, 16'h0040, 16'h0040, 4, 0);
      add("c50_ovf",   1, 1, 0, 0, 1, 0, 16'h0050, 16'h0040, 4, 1);
      add("r0031",     1, 1, 0, 0, 0, 1, 16'h0000, 16'h0031, 3, 1);
      add("r0021",     1, 1, 0, 0, 0, 1, 16'h0000, 16'h0021, 2, 1);
      add("r0011",     1, 1, 0, 0, 0, 1, 16'h0000, 16'h0011, 1, 1);
      add("r0001",     1, 1, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 1);
      add("r_unf",     1, 1, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 1);
      add("rst_clr",   0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add("ld_0776",   1, 1, 0, 1, 0, 0, 16'h0776, 16'h0776, 0, 0);
      add("c_0123",    1, 1, 0, 0, 1, 0, 16'h0123, 16'h0123, 1, 0);
      add("all4",      1, 1, 1, 1, 1, 1, 16'h0ABC, 16'h0777, 0, 0);
      add("stall1",    1, 0, 1, 0, 0, 0, 16'h0000, 16'h0777, 0, 0);
      add("stall2",    1, 0, 1, 0, 0, 0, 16'h0000, 16'h0777, 0, 0);
      add("stall3",    1, 0, 1, 0, 0, 0, 16'h0000, 16'h0777, 0, 0);
      add("call_ld",   1, 1, 0, 1, 1, 0, 16'h0ABC, 16'h0ABC, 1, 0);
      add("ret0778",   1, 1, 0, 0, 0, 1, 16'h0000, 16'h0778, 0, 0);
      add("p1",        1, 1, 0, 0, 1, 0, 16'h0100, 16'h0100, 1, 0);
      add("p2",        1, 1, 0, 0, 1, 0, 16'h0200, 16'h0200, 2, 0);
      add("mid_rst",   0, 0, 1, 0, 1, 0, 16'h0300, 16'h0000, 0, 0);
      add("ret_unf",   1, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1);
      add("ld_ffff",   1, 1, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1);
      add("c_wrap",    1, 1, 0, 0, 1, 0, 16'h0005, 16'h0005, 1, 1);
      add("r_wrap",    1, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1);

      foreach (vecs[k]) begin
         step(vecs[k].rst_n, vecs[k].en, vecs[k].inc, vecs[k].load, vecs[k].call,
              vecs[k].ret, vecs[k].addr);
         check_state(vecs[k].name, vecs[k].exp_pc, vecs[k].exp_depth, vecs[k].exp_err);
      end

      // Stall with every control asserted: nothing moves, then a clean pop still works.
      step(0, 1, 0, 0, 0, 0, 16'h0000);
      step(1, 1, 0, 1, 0, 0, 16'h1233);
      step(1, 1, 0, 0, 1, 0, 16'h2000);
      step(1, 1, 0, 0, 1, 0, 16'h3000);
      check_state("seq_push", 16'h3000, 2, 0);
      for (int n = 0; n < 3; n++) begin
         step(1, 0, 1, 1, 1, 1, 16'h4444);
         check_state("seq_stall", 16'h3000, 2, 0);
      end
      step(1, 1, 0, 0, 0, 1, 16'h0000);
      check_state("seq_pop1", 16'h2001, 1, 0);
      step(1, 1, 0, 0, 0, 1, 16'h0000);
      check_state("seq_pop2", 16'h1234, 0, 0);

      // Random phase against the reference model.
      step(0, 1, 0, 0, 0, 0, 16'h0000);
      model_step(0, 1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         logic        r, e, i, l, c, rt;
         logic [15:0] a;
         r  = ($urandom_range(0, 99) >= 2);
         e  = ($urandom_range(0, 99) < 85);
         i  = ($urandom_range(0, 99) < 50);
         l  = ($urandom_range(0, 99) < 12);
         c  = ($urandom_range(0, 99) < 30);
         rt = ($urandom_range(0, 99) < 25);
         a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         step(r, e, i, l, c, rt, a);
         model_step(r, e, i, l, c, rt, int'(a));
         check_state("rand", 16'(m_pc), m_stk.size(), m_err);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
